// File: rtl/param_matrix_multiplier.sv
// Sequential integer matrix multiplier Z = A * B (or A * B^T), one MAC per cycle,
// with fixed-point scaling, saturation and a strobe/ack result handshake.
module param_matrix_multiplier #(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int FRAC   = 0,
    parameter int ACC_W  = 2 * DATA_W + $clog2(K + 1),
    localparam int MAXD  = (M > K) ? ((M > N) ? M : N) : ((K > N) ? K : N),
    localparam int IDX_W = (MAXD > 1) ? $clog2(MAXD) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              trans_b,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [IDX_W-1:0]  a_i,
    output logic [IDX_W-1:0]  a_j,
    output logic [IDX_W-1:0]  b_i,
    output logic [IDX_W-1:0]  b_j,
    output logic [DATA_W-1:0] z_out,
    output logic [IDX_W-1:0]  z_i,
    output logic [IDX_W-1:0]  z_j,
    output logic              z_stb,
    input  logic              z_ack,
    output logic              busy,
    output logic              done,
    output logic              sat
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

    localparam logic signed [ACC_W-1:0] Z_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Z_MIN = ~Z_MAX;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      trans_q, trans_d;
    logic [IDX_W-1:0]          a_i_q, a_i_d, a_j_q, a_j_d, b_i_q, b_i_d, b_j_q, b_j_d;
    logic [DATA_W-1:0]         z_out_q, z_out_d;
    logic [IDX_W-1:0]          z_i_q, z_i_d, z_j_q, z_j_d;
    logic                      z_stb_q, z_stb_d, busy_q, busy_d, done_q, done_d, sat_q, sat_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    shifted;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        trans_d = trans_q;
        a_i_d   = a_i_q;
        a_j_d   = a_j_q;
        b_i_d   = b_i_q;
        b_j_d   = b_j_q;
        z_out_d = z_out_q;
        z_i_d   = z_i_q;
        z_j_d   = z_j_q;
        z_stb_d = z_stb_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sat_d   = sat_q;

        prod    = (2*DATA_W)'($signed(a_in)) * (2*DATA_W)'($signed(b_in));
        sum     = acc_q + ACC_W'(prod);
        shifted = sum >>> FRAC;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_MAC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    trans_d = trans_b;
                    a_i_d   = '0;
                    a_j_d   = '0;
                    b_i_d   = '0;
                    b_j_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    sat_d   = 1'b0;
                end
            end
            S_MAC: begin
                acc_d = sum;
                if (k_q == IDX_W'(K - 1)) begin
                    state_d = S_OUT;
                    z_stb_d = 1'b1;
                    z_i_d   = i_q;
                    z_j_d   = j_q;
                    if (shifted > Z_MAX) begin
                        z_out_d = Z_MAX[DATA_W-1:0];
                        sat_d   = 1'b1;
                    end else if (shifted < Z_MIN) begin
                        z_out_d = Z_MIN[DATA_W-1:0];
                        sat_d   = 1'b1;
                    end else begin
                        z_out_d = shifted[DATA_W-1:0];
                    end
                end else begin
                    // Index outputs are registered one step ahead so they match k during each MAC cycle.
                    k_d   = k_q + 1'b1;
                    a_j_d = k_q + 1'b1;
                    if (trans_q) b_j_d = k_q + 1'b1;
                    else         b_i_d = k_q + 1'b1;
                end
            end
            S_OUT: begin
                if (z_ack) begin
                    z_stb_d = 1'b0;
                    if (i_q == IDX_W'(M - 1) && j_q == IDX_W'(N - 1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (j_q == IDX_W'(N - 1)) begin
                            i_d = i_q + 1'b1;
                            j_d = '0;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                        state_d = S_MAC;
                        acc_d   = '0;
                        k_d     = '0;
                        a_i_d   = i_d;
                        a_j_d   = '0;
                        b_i_d   = trans_q ? j_d : '0;
                        b_j_d   = trans_q ? '0 : j_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            trans_q <= 1'b0;
            a_i_q   <= '0;
            a_j_q   <= '0;
            b_i_q   <= '0;
            b_j_q   <= '0;
            z_out_q <= '0;
            z_i_q   <= '0;
            z_j_q   <= '0;
            z_stb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            trans_q <= trans_d;
            a_i_q   <= a_i_d;
            a_j_q   <= a_j_d;
            b_i_q   <= b_i_d;
            b_j_q   <= b_j_d;
            z_out_q <= z_out_d;
            z_i_q   <= z_i_d;
            z_j_q   <= z_j_d;
            z_stb_q <= z_stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign a_i   = a_i_q;
    assign a_j   = a_j_q;
    assign b_i   = b_i_q;
    assign b_j   = b_j_q;
    assign z_out = z_out_q;
    assign z_i   = z_i_q;
    assign z_j   = z_j_q;
    assign z_stb = z_stb_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_param_matrix_multiplier.sv
// Bench for param_matrix_multiplier: four shapes/widths driven from behavioural operand
// memories, checked against directed tables and a plain-arithmetic matrix product model.
module tb_param_matrix_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance configs: 0: 2x2x2 w32, 1: 2x3x4 w32, 2: 2x2x2 w8, 3: 1x1x2 w8 frac4
    int cfg_m[4] = '{2, 2, 2, 1};
    int cfg_k[4] = '{2, 3, 2, 1};
    int cfg_n[4] = '{2, 4, 2, 2};
    int cfg_w[4] = '{32, 32, 8, 8};
    int cfg_f[4] = '{0, 0, 0, 4};

    logic start_s[4], trb_s[4], ack_s[4];
    logic stb_s[4], bsy_s[4], dn_s[4], sat_s[4];
    int   zo[4], zi[4], zj[4], ai[4], aj[4], bi[4], bj[4];
    int   mem_a[4][16];
    int   mem_b[4][16];
    bit   tr_run[4];

    int checks = 0;
    int failures = 0;

    logic [0:0]  ai0, aj0, bi0, bj0, zi0, zj0;
    logic [31:0] ain0, bin0, zo0;
    logic [1:0]  ai1, aj1, bi1, bj1, zi1, zj1;
    logic [31:0] ain1, bin1, zo1;
    logic [0:0]  ai2, aj2, bi2, bj2, zi2, zj2;
    logic [7:0]  ain2, bin2, zo2;
    logic [0:0]  ai3, aj3, bi3, bj3, zi3, zj3;
    logic [7:0]  ain3, bin3, zo3;

    // A is MxK row-major; B is KxN row-major, or NxK row-major when transposed.
    assign ain0 = mem_a[0][ai[0]*cfg_k[0] + aj[0]];
    assign bin0 = mem_b[0][bi[0]*(tr_run[0] ? cfg_k[0] : cfg_n[0]) + bj[0]];
    assign ain1 = mem_a[1][ai[1]*cfg_k[1] + aj[1]];
    assign bin1 = mem_b[1][bi[1]*(tr_run[1] ? cfg_k[1] : cfg_n[1]) + bj[1]];
    assign ain2 = 8'(mem_a[2][ai[2]*cfg_k[2] + aj[2]]);
    assign bin2 = 8'(mem_b[2][bi[2]*(tr_run[2] ? cfg_k[2] : cfg_n[2]) + bj[2]]);
    assign ain3 = 8'(mem_a[3][ai[3]*cfg_k[3] + aj[3]]);
    assign bin3 = 8'(mem_b[3][bi[3]*(tr_run[3] ? cfg_k[3] : cfg_n[3]) + bj[3]]);

    assign zo[0] = int'($signed(zo0));
    assign zo[1] = int'($signed(zo1));
    assign zo[2] = int'($signed(zo2));
    assign zo[3] = int'($signed(zo3));
    assign ai[0] = int'(ai0); assign aj[0] = int'(aj0); assign bi[0] = int'(bi0); assign bj[0] = int'(bj0);
    assign ai[1] = int'(ai1); assign aj[1] = int'(aj1); assign bi[1] = int'(bi1); assign bj[1] = int'(bj1);
    assign ai[2] = int'(ai2); assign aj[2] = int'(aj2); assign bi[2] = int'(bi2); assign bj[2] = int'(bj2);
    assign ai[3] = int'(ai3); assign aj[3] = int'(aj3); assign bi[3] = int'(bi3); assign bj[3] = int'(bj3);
    assign zi[0] = int'(zi0); assign zj[0] = int'(zj0); assign zi[1] = int'(zi1); assign zj[1] = int'(zj1);
    assign zi[2] = int'(zi2); assign zj[2] = int'(zj2); assign zi[3] = int'(zi3); assign zj[3] = int'(zj3);

    param_matrix_multiplier #(.M(2), .K(2), .N(2), .DATA_W(32), .FRAC(0)) u_sq32 (
        .clk(clk), .rst(rst), .start(start_s[0]), .trans_b(trb_s[0]),
        .a_in(ain0), .b_in(bin0), .a_i(ai0), .a_j(aj0), .b_i(bi0), .b_j(bj0),
        .z_out(zo0), .z_i(zi0), .z_j(zj0), .z_stb(stb_s[0]), .z_ack(ack_s[0]),
        .busy(bsy_s[0]), .done(dn_s[0]), .sat(sat_s[0]));

    param_matrix_multiplier #(.M(2), .K(3), .N(4), .DATA_W(32), .FRAC(0)) u_rect32 (
        .clk(clk), .rst(rst), .start(start_s[1]), .trans_b(trb_s[1]),
        .a_in(ain1), .b_in(bin1), .a_i(ai1), .a_j(aj1), .b_i(bi1), .b_j(bj1),
        .z_out(zo1), .z_i(zi1), .z_j(zj1), .z_stb(stb_s[1]), .z_ack(ack_s[1]),
        .busy(bsy_s[1]), .done(dn_s[1]), .sat(sat_s[1]));

    param_matrix_multiplier #(.M(2), .K(2), .N(2), .DATA_W(8), .FRAC(0)) u_sat8 (
        .clk(clk), .rst(rst), .start(start_s[2]), .trans_b(trb_s[2]),
        .a_in(ain2), .b_in(bin2), .a_i(ai2), .a_j(aj2), .b_i(bi2), .b_j(bj2),
        .z_out(zo2), .z_i(zi2), .z_j(zj2), .z_stb(stb_s[2]), .z_ack(ack_s[2]),
        .busy(bsy_s[2]), .done(dn_s[2]), .sat(sat_s[2]));

    param_matrix_multiplier #(.M(1), .K(1), .N(2), .DATA_W(8), .FRAC(4)) u_fix8 (
        .clk(clk), .rst(rst), .start(start_s[3]), .trans_b(trb_s[3]),
        .a_in(ain3), .b_in(bin3), .a_i(ai3), .a_j(aj3), .b_i(bi3), .b_j(bj3),
        .z_out(zo3), .z_i(zi3), .z_j(zj3), .z_stb(stb_s[3]), .z_ack(ack_s[3]),
        .busy(bsy_s[3]), .done(dn_s[3]), .sat(sat_s[3]));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: Z[i][j] = sum_k A[i][k]*B[k][j], then arithmetic shift and clamp.
    function automatic void model(input int n, input bit tr, output int z[16], output bit s);
        longint acc, r, hi, lo, bv;
        hi = (longint'(1) <<< (cfg_w[n] - 1)) - 1;
        lo = -hi - 1;
        s = 1'b0;
        for (int x = 0; x < 16; x++) z[x] = 0;
        for (int i = 0; i < cfg_m[n]; i++) begin
            for (int j = 0; j < cfg_n[n]; j++) begin
                acc = 0;
                for (int k = 0; k < cfg_k[n]; k++) begin
                    bv = tr ? mem_b[n][j*cfg_k[n] + k] : mem_b[n][k*cfg_n[n] + j];
                    acc += longint'(mem_a[n][i*cfg_k[n] + k]) * bv;
                end
                r = acc >>> cfg_f[n];
                if (r > hi) begin r = hi; s = 1'b1; end
                else if (r < lo) begin r = lo; s = 1'b1; end
                z[i*cfg_n[n] + j] = int'(r);
            end
        end
    endfunction

    // mode 0: z_ack tied high; 1: ack one cycle after stb; 2: random 0..3 cycle delay
    task automatic run(input int n, input bit tr, input int mode, input int ez[16],
                       input bit es, input string tag);
        int m, kk, nn, cyc, cnt, wl, first, cz, ci, cj;
        bit seen;
        m = cfg_m[n]; kk = cfg_k[n]; nn = cfg_n[n];
        cnt = 0; seen = 1'b0; wl = 0; first = -1; cyc = 0; cz = 0; ci = 0; cj = 0;
        step();
        tr_run[n] = tr; trb_s[n] = tr; ack_s[n] = (mode == 0); start_s[n] = 1'b1;
        step();
        start_s[n] = 1'b0;
        trb_s[n] = ~tr;
        chk({tag, "/busy_after_start"}, bsy_s[n], 1);
        chk({tag, "/sat_cleared"}, sat_s[n], 0);
        while (!dn_s[n] && cyc < 500) begin
            if (stb_s[n]) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (first < 0) first = cyc;
                    cz = zo[n]; ci = zi[n]; cj = zj[n];
                    chk({tag, "/z_out"}, cz, ez[cnt % 16]);
                    chk({tag, "/z_i"}, ci, cnt / nn);
                    chk({tag, "/z_j"}, cj, cnt % nn);
                    wl = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
                end else begin
                    chk({tag, "/held_changed"}, (zo[n] != cz) || (zi[n] != ci) || (zj[n] != cj), 0);
                end
                if (wl == 0) begin
                    ack_s[n] = 1'b1;
                    seen = 1'b0;
                    cnt++;
                end else begin
                    ack_s[n] = 1'b0;
                    wl--;
                end
            end else if (mode != 0) begin
                ack_s[n] = 1'b0;
            end
            step();
            cyc++;
        end
        chk({tag, "/done_reached"}, dn_s[n], 1);
        chk({tag, "/elem_count"}, cnt, m * nn);
        chk({tag, "/sat"}, sat_s[n], es);
        chk({tag, "/busy_end"}, bsy_s[n], 0);
        chk({tag, "/stb_end"}, stb_s[n], 0);
        if (mode == 0) begin
            chk({tag, "/first_stb_cycle"}, first, kk);
            chk({tag, "/done_latency"}, cyc, m * nn * (kk + 1));
        end
        ack_s[n] = 1'b0;
    endtask

    typedef struct {
        int n;
        bit tr;
        int mode;
        int a[16];
        int b[16];
        int z[16];
        bit s;
    } vec_t;

    vec_t tbl[7];

    task automatic rand_mem(input int n);
        for (int x = 0; x < 16; x++) begin
            if (cfg_w[n] == 32) begin
                mem_a[n][x] = int'($urandom_range(0, 2000000)) - 1000000;
                mem_b[n][x] = int'($urandom_range(0, 2000000)) - 1000000;
            end else begin
                mem_a[n][x] = int'($urandom_range(0, 255)) - 128;
                mem_b[n][x] = int'($urandom_range(0, 255)) - 128;
            end
        end
    endtask

    initial begin
        int ez[16];
        bit es, tr;
        int cz, ci, cj, w;

        for (int n = 0; n < 4; n++) begin
            start_s[n] = 1'b0; trb_s[n] = 1'b0; ack_s[n] = 1'b0; tr_run[n] = 1'b0;
            for (int x = 0; x < 16; x++) begin mem_a[n][x] = 0; mem_b[n][x] = 0; end
        end

        tbl[0].n = 0; tbl[0].tr = 0; tbl[0].mode = 0; tbl[0].s = 0;
        tbl[0].a = '{1,0,0,1, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[0].b = '{1,2,3,4, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[0].z = '{1,2,3,4, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[1].n = 1; tbl[1].tr = 0; tbl[1].mode = 1; tbl[1].s = 0;
        tbl[1].a = '{1,2,3,4, 5,6,0,0, 0,0,0,0, 0,0,0,0};
        tbl[1].b = '{1,2,3,4, 5,6,7,8, 9,10,11,12, 0,0,0,0};
        tbl[1].z = '{38,44,50,56, 83,98,113,128, 0,0,0,0, 0,0,0,0};
        tbl[2].n = 0; tbl[2].tr = 1; tbl[2].mode = 2; tbl[2].s = 0;
        tbl[2].a = '{1,2,3,4, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[2].b = '{5,6,7,8, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[2].z = '{17,23,39,53, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[3].n = 2; tbl[3].tr = 0; tbl[3].mode = 0; tbl[3].s = 1;
        tbl[3].a = '{127,127,127,127, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[3].b = '{127,127,127,127, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[3].z = '{127,127,127,127, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[4].n = 2; tbl[4].tr = 0; tbl[4].mode = 1; tbl[4].s = 1;
        tbl[4].a = '{-128,-128,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[4].b = '{1,1,1,1, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[4].z = '{-128,-128,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[5].n = 3; tbl[5].tr = 0; tbl[5].mode = 0; tbl[5].s = 0;
        tbl[5].a = '{48,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[5].b = '{24,16,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[5].z = '{72,48,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[6].n = 3; tbl[6].tr = 0; tbl[6].mode = 2; tbl[6].s = 0;
        tbl[6].a = '{-1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[6].b = '{1,-16,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        tbl[6].z = '{-1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};

        rst = 1'b1;
        repeat (3) step();
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("reset%0d/flags", n), {stb_s[n], bsy_s[n], dn_s[n], sat_s[n]}, 0);
            chk($sformatf("reset%0d/z_out", n), zo[n], 0);
            chk($sformatf("reset%0d/indices", n), ai[n] + aj[n] + bi[n] + bj[n] + zi[n] + zj[n], 0);
        end
        rst = 1'b0;

        for (int r = 0; r < 7; r++) begin
            mem_a[tbl[r].n] = tbl[r].a;
            mem_b[tbl[r].n] = tbl[r].b;
            run(tbl[r].n, tbl[r].tr, tbl[r].mode, tbl[r].z, tbl[r].s, $sformatf("vec%0d", r));
        end

        // Stall in OUT with z_ack low, stray start, then reset mid-operation.
        rand_mem(0);
        model(0, 1'b0, ez, es);
        step();
        tr_run[0] = 1'b0; trb_s[0] = 1'b0; ack_s[0] = 1'b0; start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        w = 0;
        while (!stb_s[0] && w < 50) begin step(); w++; end
        chk("stall/stb_seen", stb_s[0], 1);
        chk("stall/first_z", zo[0], ez[0]);
        cz = zo[0]; ci = zi[0]; cj = zj[0];
        for (int c = 0; c < 5; c++) begin
            start_s[0] = (c == 2);
            step();
            chk("stall/held_changed", (zo[0] != cz) || (zi[0] != ci) || (zj[0] != cj), 0);
            chk("stall/stb_held", stb_s[0], 1);
        end
        start_s[0] = 1'b0;
        chk("stall/busy", bsy_s[0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst/flags", {stb_s[0], bsy_s[0], dn_s[0], sat_s[0]}, 0);
        chk("midrst/z_out", zo[0], 0);
        step();
        chk("midrst/stb_stays_low", stb_s[0], 0);
        run(0, 1'b0, 0, ez, es, "after_rst");

        // start coincident with reset is dropped
        rst = 1'b1; start_s[0] = 1'b1;
        step();
        rst = 1'b0; start_s[0] = 1'b0;
        chk("rst_start/busy", bsy_s[0], 0);
        step();
        chk("rst_start/busy_later", bsy_s[0], 0);

        for (int rep = 0; rep < 6; rep++) begin
            for (int n = 0; n < 4; n++) begin
                rand_mem(n);
                tr = 1'($urandom_range(0, 1));
                model(n, tr, ez, es);
                run(n, tr, int'($urandom_range(0, 2)), ez, es, $sformatf("rnd%0d_%0d", rep, n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
